trace_tx_scheduler: RTL and testbench

//  Turns probe transitions into timestamped 4-byte trace records and schedules them

---
 rtl/wiretrace_pkg.sv | 16 +
 rtl/trace_event_fifo.sv | 55 +++++
 rtl/trace_tx_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_trace_tx_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wiretrace_pkg.sv
// Shared constants and record-scheduler state encoding for the trace path.
package wiretrace_pkg;

    localparam logic [7:0]  SYNC_OK   = 8'hA5;
    localparam logic [7:0]  SYNC_LOST = 8'hA7;
    localparam int unsigned REC_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_VAL  = 3'd2,
        ST_TSH  = 3'd3,
        ST_TSL  = 3'd4
    } rec_state_t;

endpackage

// File: rtl/trace_event_fifo.sv
// Synchronous event FIFO; a pop frees its slot before a same-cycle push is judged.
module trace_event_fifo #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LV_W  = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_pop;
    logic              do_push;
    logic [LV_W-1:0]   level_next;

    assign do_pop     = pop & ~empty;
    assign do_push    = push & (~full | do_pop);
    assign level_next = level + LV_W'(do_push) - LV_W'(do_pop);
    assign rd_data    = mem[rd_ptr];

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, fill level and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_next;
            full  <= (level_next == LV_W'(DEPTH));
            empty <= (level_next == '0);
        end
    end

endmodule

// File: rtl/trace_tx_scheduler.sv
// Timestamps probe transitions, queues them and streams 4-byte records to the UART.
module trace_tx_scheduler
    import wiretrace_pkg::*;
#(
    parameter int unsigned PROBE_W = 8,
    parameter int unsigned TS_W    = 16,
    parameter int unsigned TS_DIV  = 24,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic               clk24,
    input  logic               rst,
    input  logic               enable,
    input  logic [PROBE_W-1:0] probes_in,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               overflow,
    output logic [7:0]         drop_count,
    output logic               busy
);
    localparam int unsigned EV_W = PROBE_W + TS_W;
    localparam int unsigned PS_W = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
    localparam int unsigned LV_W = FIFO_AW + 1;

    logic [PS_W-1:0]    presc;
    logic [PS_W-1:0]    presc_next;
    logic [TS_W-1:0]    ts;
    logic [TS_W-1:0]    ts_next;
    logic               en_q;
    logic               rose;
    logic               presc_wrap;
    logic               ts_wrap;
    logic               push;
    logic               push_ok;
    logic               drop;
    logic [PROBE_W-1:0] last;

    logic               fifo_full;
    logic               fifo_empty;
    logic [LV_W-1:0]    fifo_level;
    logic [LV_W-1:0]    level_after;
    logic [EV_W-1:0]    fifo_rd;

    rec_state_t         state;
    rec_state_t         state_next;
    logic               pop;
    logic               tx_accept;
    logic               tx_valid_d;
    logic [7:0]         tx_data_d;
    logic [7:0]         hdr_byte;
    logic [PROBE_W-1:0] rec_val;
    logic [TS_W-1:0]    rec_ts;
    logic               lost;
    logic               lost_next;

    assign rose        = enable & ~en_q;
    assign presc_wrap  = (presc == PS_W'(TS_DIV - 1));
    assign ts_wrap     = enable & ~rose & presc_wrap & (&ts);
    assign push        = enable & (rose | (probes_in != last) | ts_wrap);
    assign drop        = push & fifo_full & ~pop;
    assign push_ok     = push & ~drop;
    assign tx_accept   = tx_valid & tx_ready;
    assign hdr_byte    = lost ? SYNC_LOST : SYNC_OK;
    assign lost_next   = drop | (lost & ~pop);
    assign level_after = fifo_level + LV_W'(push_ok) - LV_W'(pop);

    // Prescaler and timestamp advance; an enable rising edge restarts both at zero.
    always_comb begin
        presc_next = presc;
        ts_next    = ts;
        if (rose) begin
            presc_next = '0;
            ts_next    = '0;
        end else if (enable) begin
            if (presc_wrap) begin
                presc_next = '0;
                ts_next    = ts + TS_W'(1);
            end else begin
                presc_next = presc + PS_W'(1);
            end
        end
    end

    trace_event_fifo #(
        .DATA_W (EV_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk     (clk24),
        .rst     (rst),
        .push    (push),
        .wr_data ({probes_in, ts_next}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Record FSM state register.
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Record FSM next state: each byte waits for its handshake.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (!fifo_empty) state_next = ST_HDR;
            ST_HDR:  if (tx_accept)   state_next = ST_VAL;
            ST_VAL:  if (tx_accept)   state_next = ST_TSH;
            ST_TSH:  if (tx_accept)   state_next = ST_TSL;
            ST_TSL:  if (tx_accept)   state_next = fifo_empty ? ST_IDLE : ST_HDR;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Record FSM outputs: pop strobe and the next byte/valid to present.
    always_comb begin
        pop        = 1'b0;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = hdr_byte;
                end
            end
            ST_HDR: if (tx_accept) tx_data_d = 8'(rec_val);
            ST_VAL: if (tx_accept) tx_data_d = rec_ts[TS_W-1 -: 8];
            ST_TSH: if (tx_accept) tx_data_d = rec_ts[7:0];
            ST_TSL: begin
                if (tx_accept) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        tx_data_d = hdr_byte;
                    end else begin
                        tx_valid_d = 1'b0;
                    end
                end
            end
            default: tx_valid_d = 1'b0;
        endcase
    end

    // Timestamp counters and change-detect history.
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            presc <= '0;
            ts    <= '0;
            en_q  <= 1'b0;
            last  <= '0;
        end else begin
            presc <= presc_next;
            ts    <= ts_next;
            en_q  <= enable;
            if (push) last <= probes_in;
        end
    end

    // Record registers, byte outputs, loss tracking and busy flag.
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            rec_val    <= '0;
            rec_ts     <= '0;
            lost       <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= 8'h00;
            busy       <= 1'b0;
        end else begin
            tx_valid <= tx_valid_d;
            tx_data  <= tx_data_d;
            if (pop) begin
                rec_val <= fifo_rd[EV_W-1 -: PROBE_W];
                rec_ts  <= fifo_rd[TS_W-1:0];
            end
            lost <= lost_next;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
            busy <= (level_after != '0) | (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_trace_tx_scheduler.sv
// Scoreboard bench: reference model queues expected bytes, monitor checks accepted bytes.
module tb_trace_tx_scheduler;
    import wiretrace_pkg::*;

    localparam int unsigned TS_DIV = 1;
    localparam int unsigned DEPTH  = 16;

    logic       clk24 = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] probes_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       overflow;
    logic [7:0] drop_count;
    logic       busy;

    int tests = 0;
    int fails = 0;

    always #5 clk24 = ~clk24;

    trace_tx_scheduler #(
        .PROBE_W (8),
        .TS_W    (16),
        .TS_DIV  (TS_DIV),
        .FIFO_AW (4)
    ) dut (
        .clk24      (clk24),
        .rst        (rst),
        .enable     (enable),
        .probes_in  (probes_in),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .overflow   (overflow),
        .drop_count (drop_count),
        .busy       (busy)
    );

    // Reference model state
    logic [23:0] mq[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  seen[$];
    bit          m_in_flight = 0;
    int          m_rem = 0;
    bit          m_lost = 0;
    bit          m_ovf = 0;
    int          m_drops = 0;
    longint      m_cyc = 0;
    bit          m_en_prev = 0;
    logic [7:0]  m_last = 8'h00;
    bit          md_pop;
    bit          md_rose;
    bit          md_wrap;
    logic [23:0] md_ev;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: events are queued by rule, records leave one byte per accepted handshake.
    always @(posedge clk24) begin : ref_model
        if (rst) begin
            mq.delete();
            exp_bytes.delete();
            m_in_flight = 0;
            m_rem       = 0;
            m_lost      = 0;
            m_ovf       = 0;
            m_drops     = 0;
            m_cyc       = 0;
            m_en_prev   = 0;
            m_last      = 8'h00;
        end else begin
            md_pop = 0;
            if (!m_in_flight) begin
                md_pop = (mq.size() != 0);
            end else if (tx_ready) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_in_flight = 0;
                    md_pop = (mq.size() != 0);
                end
            end
            if (md_pop) begin
                md_ev = mq.pop_front();
                exp_bytes.push_back(m_lost ? 8'hA7 : 8'hA5);
                exp_bytes.push_back(md_ev[23:16]);
                exp_bytes.push_back(md_ev[15:8]);
                exp_bytes.push_back(md_ev[7:0]);
                m_lost      = 0;
                m_in_flight = 1;
                m_rem       = REC_BYTES;
            end
            if (enable) begin
                md_rose = !m_en_prev;
                if (md_rose) m_cyc = 0;
                else         m_cyc++;
                md_wrap = !md_rose && ((m_cyc % (TS_DIV * 65536)) == 0);
                if (md_rose || (probes_in != m_last) || md_wrap) begin
                    md_ev = {probes_in, 16'(m_cyc / TS_DIV)};
                    if (mq.size() < DEPTH) begin
                        mq.push_back(md_ev);
                    end else begin
                        m_ovf  = 1;
                        m_lost = 1;
                        if (m_drops < 255) m_drops++;
                    end
                    m_last = probes_in;
                end
            end
            m_en_prev = enable;
        end
    end

    // Monitor: sampled just before each rising edge.
    bit         hold_pend = 0;
    logic [7:0] hold_data = 8'h00;

    always @(negedge clk24) begin : monitor
        #3;
        if (rst) begin
            check("rst_valid", tx_valid, 0);
            check("rst_data", tx_data, 0);
            check("rst_busy", busy, 0);
            hold_pend = 0;
        end else begin
            check("valid", tx_valid, m_in_flight);
            check("busy", busy, (m_in_flight || mq.size() != 0));
            check("overflow", overflow, m_ovf);
            check("drop_count", drop_count, m_drops);
            if (hold_pend) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, hold_data);
            end
            if (tx_valid && tx_ready) begin
                seen.push_back(tx_data);
                if (exp_bytes.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL byte_stray: got %02h with no byte expected (t=%0t)", tx_data, $time);
                end else begin
                    check("byte", tx_data, exp_bytes.pop_front());
                end
            end
            hold_pend = tx_valid && !tx_ready;
            hold_data = tx_data;
        end
    end

    task automatic drain(input string name);
        int n = 0;
        repeat (3) @(negedge clk24);
        while ((m_in_flight || mq.size() != 0) && n < 4000) begin
            @(negedge clk24);
            n++;
        end
        repeat (2) @(negedge clk24);
        check({name, "_drain"}, int'(m_in_flight || mq.size() != 0), 0);
        check({name, "_exp_left"}, exp_bytes.size(), 0);
    endtask

    task automatic wait_cyc(input longint target, input string name);
        int n = 0;
        while (m_cyc < target && n < 80000) begin
            @(negedge clk24);
            n++;
        end
        check(name, int'(m_cyc >= target), 1);
    endtask

    task automatic check_rec(input string name, input int base,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] e[4];
        e = '{b0, b1, b2, b3};
        for (int k = 0; k < 4; k++) begin
            if (base + k < seen.size())
                check($sformatf("%s_b%0d", name, k), seen[base+k], e[k]);
            else
                check($sformatf("%s_b%0d_count", name, k), seen.size(), base + k + 1);
        end
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        rst       = 1'b1;
        enable    = 1'b1;
        probes_in = 8'h00;
        tx_ready  = 1'b1;
        repeat (3) @(negedge clk24);
        check("reset_valid", tx_valid, 0);
        check("reset_drops", drop_count, 0);
        check("reset_ovf", overflow, 0);
        rst = 1'b0;

        // Snapshot after reset
        drain("t1");
        check("t1_count", seen.size(), 4);
        check_rec("t1_snap", 0, 8'hA5, 8'h00, 8'h00, 8'h00);

        // Change at ts 0x0123 and two-edge latency
        wait_cyc(64'h122, "t2_wait");
        probes_in = 8'h03;
        @(posedge clk24); #1;
        check("t2_lat_edge1", tx_valid, 0);
        @(posedge clk24); #1;
        check("t2_lat_edge2", tx_valid, 1);
        check("t2_lat_hdr", tx_data, 8'hA5);
        base = seen.size();
        drain("t2");
        check_rec("t2_rec", base, 8'hA5, 8'h03, 8'h01, 8'h23);

        // Long stall on the VAL byte
        @(negedge clk24);
        probes_in = 8'h5A;
        base = seen.size();
        repeat (3) @(negedge clk24);
        tx_ready = 1'b0;
        repeat (50) @(negedge clk24);
        tx_ready = 1'b1;
        drain("t3");
        check("t3_count", seen.size() - base, 4);
        check_rec("t3_rec", base, 8'hA5, 8'h5A, seen[base+2], seen[base+3]);

        // Overflow burst behind a stalled record
        tx_ready  = 1'b0;
        probes_in = 8'h10;
        repeat (3) @(negedge clk24);
        for (int i = 0; i < 20; i++) begin
            probes_in = 8'(8'h20 + i);
            @(negedge clk24);
        end
        @(negedge clk24);
        check("t4_drops", drop_count, 4);
        check("t4_ovf", overflow, 1);
        base = seen.size();
        tx_ready = 1'b1;
        drain("t4");
        check("t4_bytes", seen.size() - base, 68);
        check("t4_hdr0", seen[base], 8'hA5);
        check("t4_val0", seen[base+1], 8'h10);
        check("t4_hdr1", seen[base+4], 8'hA7);
        check("t4_val1", seen[base+5], 8'h20);
        check("t4_hdr2", seen[base+8], 8'hA5);

        // Randomised traffic with enable toggling and back-pressure
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk24);
            tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            if ($urandom_range(0, 3) == 0) probes_in = 8'($urandom);
        end
        enable   = 1'b1;
        tx_ready = 1'b1;
        drain("rand");

        // Keepalive on timestamp wrap with static probes
        @(negedge clk24);
        enable = 1'b0;
        @(negedge clk24);
        enable = 1'b1;
        base = seen.size();
        wait_cyc(64'd65540, "t5_wait");
        drain("t5");
        check("t5_bytes", seen.size() - base, 8);
        check_rec("t5_keep", base + 4, 8'hA5, probes_in, 8'h00, 8'h00);

        // Reset in the middle of a record
        @(negedge clk24);
        probes_in = 8'h77;
        repeat (3) @(negedge clk24);
        tx_ready = 1'b0;
        @(negedge clk24);
        rst = 1'b1;
        #1;
        check("t6_valid", tx_valid, 0);
        check("t6_data", tx_data, 0);
        check("t6_busy", busy, 0);
        check("t6_ovf", overflow, 0);
        check("t6_drops", drop_count, 0);
        repeat (3) @(negedge clk24);
        tx_ready = 1'b1;
        base = seen.size();
        rst = 1'b0;
        drain("t6");
        check("t6_count", seen.size() - base, 4);
        check_rec("t6_snap", base, 8'hA5, 8'h77, 8'h00, 8'h00);

        repeat (5) @(negedge clk24);
        check("end_exp_empty", exp_bytes.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
